// File: rtl/dense_weight_stream_bram.sv
// Weight store for dense layers: simple-dual-port BRAM with a byte-enabled load port and a
// burst read engine that streams one word per cycle to the MAC array.
// Latency: the first beat is valid RD_LAT+1 cycles after the edge that accepts rd_start.
// Backpressure: reads are issued only while (in-flight + buffered - popping) < RD_LAT+1, so
// the skid FIFO never overflows and the stream resumes losslessly when m_ready returns.
//
// Ports:
//   clk, rst_n                        single clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_be       load port, byte enables, accepted in every state
//   rd_start/rd_base/rd_len           burst request, sampled only while idle
//   rd_busy, rd_done, err_range       engine status; done and range error are 1-cycle pulses
//   m_valid/m_data/m_last/m_ready     output stream to the datapath
module dense_weight_stream_bram #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int RD_LAT = 2,
   parameter int LEN_W  = ADDR_W + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic                rd_start,
   input  logic [ADDR_W-1:0]   rd_base,
   input  logic [LEN_W-1:0]    rd_len,
   output logic                rd_busy,
   output logic                m_valid,
   output logic [DATA_W-1:0]   m_data,
   output logic                m_last,
   input  logic                m_ready,
   output logic                rd_done,
   output logic                err_range
);

   localparam int BE_W  = DATA_W / 8;
   localparam int FD    = RD_LAT + 1;            // skid FIFO depth == number of read credits
   localparam int CNT_W = $clog2(FD + 1);
   localparam int PTR_W = (FD > 1) ? $clog2(FD) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   base_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    issued;
   logic [ADDR_W-1:0]   rd_addr;
   logic                issue;
   logic                start_ok, start_zero, start_bad;
   logic                done_nxt;
   logic [LEN_W:0]      range_end;

   // memory and read pipeline
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   pipe_dat [RD_LAT];
   logic [RD_LAT-1:0]   pipe_vld;
   logic [RD_LAT-1:0]   pipe_lst;
   logic                push, push_last;
   logic [DATA_W-1:0]   push_dat;

   // skid FIFO and credit accounting
   logic [DATA_W-1:0]   fifo_dat [FD];
   logic [FD-1:0]       fifo_lst;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    fifo_cnt;
   logic [CNT_W-1:0]    out_cnt;
   logic [CNT_W:0]      credit_sum;
   logic                credit_ok;
   logic                pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FD - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign rd_addr   = base_q + issued[ADDR_W-1:0];
   assign range_end = (LEN_W+1)'(rd_base) + (LEN_W+1)'(rd_len);

   assign m_valid = (fifo_cnt != '0);
   assign m_data  = m_valid ? fifo_dat[rd_ptr] : '0;
   assign m_last  = m_valid & fifo_lst[rd_ptr];
   assign pop     = m_valid & m_ready;
   assign rd_busy = (state != IDLE);

   // A beat leaving this cycle frees its slot at the same edge the new read is issued,
   // which is what lets the engine sustain one word per cycle with only RD_LAT+1 slots.
   assign credit_sum = {1'b0, out_cnt} + {1'b0, fifo_cnt} - {{CNT_W{1'b0}}, pop};
   assign credit_ok  = (credit_sum < (CNT_W+1)'(FD));

   assign push      = pipe_vld[RD_LAT-1];
   assign push_dat  = pipe_dat[RD_LAT-1];
   assign push_last = pipe_lst[RD_LAT-1];

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      issue      = 1'b0;
      start_ok   = 1'b0;
      start_zero = 1'b0;
      start_bad  = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (rd_start) begin
               if (rd_len == '0) begin
                  start_zero = 1'b1;
                  done_nxt   = 1'b1;
               end else if (range_end > (LEN_W+1)'(DEPTH)) begin
                  start_bad = 1'b1;
               end else begin
                  start_ok  = 1'b1;
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (issued == len_q - LEN_W'(1)) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && m_last) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_q    <= '0;
         len_q     <= '0;
         issued    <= '0;
         rd_done   <= 1'b0;
         err_range <= 1'b0;
      end else begin
         rd_done   <= done_nxt;
         err_range <= start_bad;
         if (start_ok) begin
            base_q <= rd_base;
            len_q  <= rd_len;
            issued <= '0;
         end else if (issue) begin
            issued <= issued + LEN_W'(1);
         end
      end
   end

   // ---------------- memory (read-first) and data pipeline ----------------
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < BE_W; i++) begin
            if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
      if (issue) pipe_dat[0] <= mem[rd_addr];
      for (int s = 1; s < RD_LAT; s++) pipe_dat[s] <= pipe_dat[s-1];
   end

   // valid/last travel alongside the data; clearing them on reset drops any in-flight reads
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe_vld <= '0;
         pipe_lst <= '0;
      end else begin
         pipe_vld[0] <= issue;
         pipe_lst[0] <= issue && (issued == len_q - LEN_W'(1));
         for (int s = 1; s < RD_LAT; s++) begin
            pipe_vld[s] <= pipe_vld[s-1];
            pipe_lst[s] <= pipe_lst[s-1];
         end
      end
   end

   // ---------------- skid FIFO ----------------
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_dat[wr_ptr] <= push_dat;
         fifo_lst[wr_ptr] <= push_last;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         out_cnt  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
         out_cnt  <= out_cnt + CNT_W'(issue) - CNT_W'(push);
      end
   end

endmodule

// File: tb/tb_dense_weight_stream_bram.sv
module tb_dense_weight_stream_bram;
   localparam int DATA_W = 128;
   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;
   localparam int RD_LAT = 2;
   localparam int LEN_W  = ADDR_W + 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                wr_en = 1'b0;
   logic [ADDR_W-1:0]   wr_addr = '0;
   logic [DATA_W-1:0]   wr_data = '0;
   logic [DATA_W/8-1:0] wr_be = '0;
   logic                rd_start = 1'b0;
   logic [ADDR_W-1:0]   rd_base = '0;
   logic [LEN_W-1:0]    rd_len = '0;
   logic                rd_busy, m_valid, m_last, rd_done, err_range;
   logic [DATA_W-1:0]   m_data;
   logic                m_ready = 1'b1;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic              l;
   } exp_t;

   exp_t              sb[$];
   logic [DATA_W-1:0] model [DEPTH];
   int                tests = 0;
   int                fails = 0;
   int                done_cnt = 0;
   int                err_cnt = 0;
   logic              prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_dat = '0;

   dense_weight_stream_bram #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_busy(rd_busy),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .rd_done(rd_done), .err_range(err_range)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input int addr, input logic [DATA_W-1:0] data, input logic [DATA_W/8-1:0] be);
      wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_data = data; wr_be = be;
      tick();
      wr_en = 1'b0;
      for (int i = 0; i < DATA_W/8; i++)
         if (be[i]) model[addr][8*i +: 8] = data[8*i +: 8];
   endtask

   task automatic start_burst(input int base, input int len, input bit expect_beats);
      if (expect_beats)
         for (int k = 0; k < len; k++) sb.push_back('{d: model[base+k], l: (k == len-1)});
      rd_start = 1'b1; rd_base = ADDR_W'(base); rd_len = LEN_W'(len);
      tick();
      rd_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      int i;
      d0 = done_cnt;
      i = 0;
      while (done_cnt == d0 && i < budget) begin
         tick();
         i++;
      end
      chk(tag, done_cnt - d0, 1);
   endtask

   // scoreboard / protocol monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_data", m_data, prev_dat);
         end
         if (m_valid && m_ready) begin
            chk("beat_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("beat_data", m_data, e.d);
               chk("beat_last", m_last, e.l);
            end
         end
         if (rd_busy) chk("credit_bound", (dut.out_cnt + dut.fifo_cnt) <= (RD_LAT + 1), 1'b1);
         if (rd_done) done_cnt++;
         if (err_range) err_cnt++;
      end
      prev_stall <= rst_n && m_valid && !m_ready;
      prev_dat   <= m_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, e0;
      bit [5:0] pat;

      // reset state
      tick(); tick();
      chk("rst_busy", rd_busy, 1'b0);
      chk("rst_valid", m_valid, 1'b0);
      chk("rst_last", m_last, 1'b0);
      chk("rst_done", rd_done, 1'b0);
      chk("rst_err", err_range, 1'b0);
      chk("rst_data", m_data, '0);
      rst_n = 1'b1;
      tick();

      // basic burst: latency, back-to-back beats, last, done
      for (int k = 0; k < 8; k++) write_word(k, {16{8'(k)}}, '1);
      start_burst(0, 8, 1'b1);
      chk("busy_after_start", rd_busy, 1'b1);
      for (int i = 0; i < RD_LAT + 1; i++) begin
         chk("lat_pre", m_valid, 1'b0);
         tick();
      end
      chk("lat_first", m_valid, 1'b1);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk("stream_cont", m_valid, 1'b1);
      end
      chk("last_on_beat7", m_last, 1'b1);
      tick();
      chk("done_pulse", rd_done, 1'b1);
      chk("busy_clear", rd_busy, 1'b0);
      chk("valid_clear", m_valid, 1'b0);
      tick();
      chk("done_one_cycle", rd_done, 1'b0);
      chk("sb_empty_basic", sb.size(), 0);

      // partial byte-enable write
      write_word(10, '0, '1);
      write_word(10, '1, 16'h000F);
      sb.push_back('{d: 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, l: 1'b1});
      start_burst(10, 1, 1'b0);
      wait_done("done_partial", 40);
      chk("sb_empty_partial", sb.size(), 0);

      // backpressure with m_ready pattern 1,0,0,1,0,1
      pat = 6'b101001;
      start_burst(0, 6, 1'b1);
      d0 = done_cnt;
      for (int i = 0; i < 80 && done_cnt == d0; i++) begin
         m_ready = pat[i % 6];
         tick();
      end
      m_ready = 1'b1;
      chk("done_toggle", done_cnt - d0, 1);
      chk("sb_empty_toggle", sb.size(), 0);

      // range boundary
      write_word(DEPTH-2, {8{16'hA5C3}}, '1);
      write_word(DEPTH-1, {8{16'h5A3C}}, '1);
      e0 = err_cnt; d0 = done_cnt;
      start_burst(DEPTH-2, 3, 1'b0);
      chk("err_pulse", err_range, 1'b1);
      chk("err_not_busy", rd_busy, 1'b0);
      tick();
      chk("err_one_cycle", err_range, 1'b0);
      for (int i = 0; i < 6; i++) tick();
      chk("err_still_idle", rd_busy, 1'b0);
      chk("err_count", err_cnt - e0, 1);
      chk("err_no_done", done_cnt - d0, 0);
      start_burst(DEPTH-2, 2, 1'b1);
      wait_done("done_edge_ok", 40);
      chk("sb_empty_edge", sb.size(), 0);

      // zero-length burst
      start_burst(0, 0, 1'b0);
      chk("zero_done", rd_done, 1'b1);
      chk("zero_not_busy", rd_busy, 1'b0);
      tick();
      chk("zero_done_once", rd_done, 1'b0);

      // start while busy is ignored
      d0 = done_cnt;
      start_burst(0, 4, 1'b1);
      rd_start = 1'b1; rd_base = ADDR_W'(3); rd_len = LEN_W'(2);
      tick();
      rd_start = 1'b0;
      wait_done("done_busy", 40);
      for (int i = 0; i < 10; i++) tick();
      chk("busy_single_done", done_cnt - d0, 1);
      chk("sb_empty_busy", sb.size(), 0);

      // read/write collision on address 5: old data streamed
      start_burst(5, 1, 1'b1);
      write_word(5, {4{32'hDEADBEEF}}, '1);
      wait_done("done_collide", 40);
      chk("sb_empty_collide", sb.size(), 0);
      start_burst(5, 1, 1'b1);
      wait_done("done_after_collide", 40);
      chk("sb_empty_after_collide", sb.size(), 0);

      // reset mid-burst
      d0 = done_cnt;
      start_burst(0, 8, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0; m_ready = 1'b0;
      sb.delete();
      tick();
      chk("mid_rst_valid", m_valid, 1'b0);
      chk("mid_rst_busy", rd_busy, 1'b0);
      chk("mid_rst_last", m_last, 1'b0);
      chk("mid_rst_data", m_data, '0);
      chk("mid_rst_done", rd_done, 1'b0);
      tick();
      rst_n = 1'b1; m_ready = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("mid_rst_no_done", done_cnt - d0, 0);
      start_burst(1, 3, 1'b1);
      wait_done("done_after_rst", 40);
      chk("sb_empty_after_rst", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
